// File: rtl/dr4_tx_if.sv
// dr4_tx_if: producer valid/ready bundle plus dual-rail channel to the receiver.
// master drives the word and the acknowledge; slave is the transmitter.
interface dr4_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_t;
  logic [WIDTH-1:0] out_f;
  logic             out_ack;

  modport master (
    output in_valid,
    output in_data,
    output out_ack,
    input  in_ready,
    input  out_t,
    input  out_f
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ack,
    output in_ready,
    output out_t,
    output out_f
  );
endinterface

// File: rtl/dr4_tx.sv
// dr4_tx: clocked initiator for a four-phase RTZ dual-rail latch channel.
// Define DR4_TX_TIMEOUT_EN to build the sticky acknowledge-timeout monitor.
module dr4_tx #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic    clk,
  input  logic    rst_n,
  dr4_tx_if.slave bus,
  output logic    busy,
  output logic    timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [WIDTH-1:0]       t_q, t_d;
  logic [WIDTH-1:0]       f_q, f_d;
  logic                   accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.out_ack};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Ready is held low through reset so no word is taken while rails are forced.
  assign bus.in_ready = rst_n && (state_q == IDLE) && !ack_s;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    f_d     = f_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          t_d     = bus.in_data;
          f_d     = ~bus.in_data;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          t_d     = '0;
          f_d     = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        t_d     = '0;
        f_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      f_q     <= f_d;
    end
  end

  assign bus.out_t = t_q;
  assign bus.out_f = f_q;
  assign busy      = (state_q != IDLE);

`ifdef DR4_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // Counter saturates; the FSM keeps waiting after the flag is raised.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE && cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | (cnt_d == LIMIT);
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
